esp_rx_monitor: RTL and testbench

ESP_RX_MONITOR -- requirements
Module: esp_rx_monitor

---
 rtl/esp_rx_monitor.sv | 229 ++++++++++++++++++++++
 tb/tb_esp_rx_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/esp_rx_monitor.sv
// esp_rx_monitor
//   UART receiver (8N1, LSB first) for the ESP8266 TX line, with optional
//   detectors for the "OK\r\n" and "ready\r\n" response strings.
//
//   Optional feature macro: ESP_RX_MATCH_EN
//     defined   -> OK / ready matchers are built
//     undefined -> ok_det and ready_det are tied to 0
//
// Ports
//   clk        in   system clock, all logic on posedge
//   sys_rst_n  in   asynchronous active-low reset
//   rx         in   serial line (idle high), asynchronous to clk
//   rx_data    out  [7:0] last correctly framed byte
//   rx_valid   out  one-cycle pulse when rx_data is updated
//   frame_err  out  one-cycle pulse when the stop bit is sampled low
//   ok_det     out  one-cycle pulse after "OK\r\n"
//   ready_det  out  one-cycle pulse after "ready\r\n"
module esp_rx_monitor #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       ok_det,
  output logic       ready_det
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_RECOVER
  } state_e;

  logic             rx_s1_q, rx_s2_q;
  logic             rx_sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             mid_tick, bit_tick;

  assign rx_sync  = rx_s2_q;
  assign mid_tick = (cnt_q == HALF_CNT);
  // Data and stop samples fall one full bit period after the previous sample.
  assign bit_tick = (cnt_q == FULL_CNT);

  // State register
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  // Synchronizer and datapath registers
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_s1_q     <= rx;
      rx_s2_q     <= rx_s1_q;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!rx_sync) state_d = S_START;
      // A start bit that is high again at its midpoint is treated as a glitch.
      S_START:   if (mid_tick) state_d = rx_sync ? S_IDLE : S_DATA;
      S_DATA:    if (bit_tick && (bit_idx_q == 3'd7)) state_d = S_STOP;
      S_STOP:    if (bit_tick) state_d = rx_sync ? S_IDLE : S_RECOVER;
      // Wait for the line to go idle so a held-low line is not read as bytes.
      S_RECOVER: if (rx_sync) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
      end
      S_START: begin
        cnt_d     = mid_tick ? '0 : cnt_q + CNT_ONE;
        bit_idx_d = '0;
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d     = '0;
          shift_d   = {rx_sync, shift_q[7:1]};  // LSB arrives first
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (rx_sync) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: cnt_d = '0;
    endcase
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;

`ifdef ESP_RX_MATCH_EN
  function automatic logic [7:0] ok_char(input logic [1:0] i);
    case (i)
      2'd0:    ok_char = 8'h4F;  // 'O'
      2'd1:    ok_char = 8'h4B;  // 'K'
      2'd2:    ok_char = 8'h0D;
      default: ok_char = 8'h0A;
    endcase
  endfunction

  function automatic logic [7:0] ready_char(input logic [2:0] i);
    case (i)
      3'd0:    ready_char = 8'h72;  // 'r'
      3'd1:    ready_char = 8'h65;  // 'e'
      3'd2:    ready_char = 8'h61;  // 'a'
      3'd3:    ready_char = 8'h64;  // 'd'
      3'd4:    ready_char = 8'h79;  // 'y'
      3'd5:    ready_char = 8'h0D;
      default: ready_char = 8'h0A;
    endcase
  endfunction

  logic [1:0] ok_idx_q, ok_idx_d;
  logic [2:0] rdy_idx_q, rdy_idx_d;
  logic       ok_det_q, ok_det_d;
  logic       rdy_det_q, rdy_det_d;

  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ok_idx_q  <= '0;
      rdy_idx_q <= '0;
      ok_det_q  <= 1'b0;
      rdy_det_q <= 1'b0;
    end else begin
      ok_idx_q  <= ok_idx_d;
      rdy_idx_q <= rdy_idx_d;
      ok_det_q  <= ok_det_d;
      rdy_det_q <= rdy_det_d;
    end
  end

  // Matchers consume the registered byte, so *_det lands one cycle after rx_valid.
  // On a mismatch the byte may itself restart the sequence.
  always_comb begin
    ok_idx_d  = ok_idx_q;
    rdy_idx_d = rdy_idx_q;
    ok_det_d  = 1'b0;
    rdy_det_d = 1'b0;
    if (frame_err_q) begin
      ok_idx_d  = '0;
      rdy_idx_d = '0;
    end else if (rx_valid_q) begin
      if (rx_data_q == ok_char(ok_idx_q)) begin
        if (ok_idx_q == 2'd3) begin
          ok_idx_d = '0;
          ok_det_d = 1'b1;
        end else begin
          ok_idx_d = ok_idx_q + 2'd1;
        end
      end else begin
        ok_idx_d = (rx_data_q == 8'h4F) ? 2'd1 : 2'd0;
      end
      if (rx_data_q == ready_char(rdy_idx_q)) begin
        if (rdy_idx_q == 3'd6) begin
          rdy_idx_d = '0;
          rdy_det_d = 1'b1;
        end else begin
          rdy_idx_d = rdy_idx_q + 3'd1;
        end
      end else begin
        rdy_idx_d = (rx_data_q == 8'h72) ? 3'd1 : 3'd0;
      end
    end
  end

  assign ok_det    = ok_det_q;
  assign ready_det = rdy_det_q;
`else
  assign ok_det    = 1'b0;
  assign ready_det = 1'b0;
`endif

endmodule

// File: tb/tb_esp_rx_monitor.sv
// Self-checking bench for esp_rx_monitor (CLKS_PER_BIT = 16).
// Expected behaviour comes from a byte-level model: every good frame appends
// its byte to a history, a detection is expected whenever the history ends
// with the target string, and a framing error wipes the history.
module tb_esp_rx_monitor;
  localparam int CPB = 16;
`ifdef ESP_RX_MATCH_EN
  localparam bit MATCH_EN = 1'b1;
`else
  localparam bit MATCH_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sys_rst_n;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, ok_det, ready_det;

  int errors = 0;
  int checks = 0;

  esp_rx_monitor #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .sys_rst_n (sys_rst_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .ok_det    (ok_det),
    .ready_det (ready_det)
  );

  always #5 clk = ~clk;

  // Observed event counters, sampled on the falling edge.
  int         n_valid = 0, n_ferr = 0, n_ok = 0, n_ready = 0;
  int         n_ok_timed = 0, n_ready_timed = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  always @(negedge clk) begin
    if (rx_valid)  n_valid++;
    if (frame_err) n_ferr++;
    if (ok_det) begin
      n_ok++;
      if (prev_valid && prev_data == 8'h0A) n_ok_timed++;
    end
    if (ready_det) begin
      n_ready++;
      if (prev_valid && prev_data == 8'h0A) n_ready_timed++;
    end
    prev_valid = rx_valid;
    prev_data  = rx_data;
  end

  // Reference model state.
  int         exp_valid = 0, exp_ferr = 0, exp_ok = 0, exp_ready = 0;
  logic [7:0] exp_data  = 8'h00;
  logic [7:0] hist[$];

  function automatic bit ends_with(input string s);
    int n = s.len();
    if (hist.size() < n) return 1'b0;
    for (int i = 0; i < n; i++)
      if (hist[hist.size() - n + i] != s[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit stop);
    if (stop) begin
      exp_valid++;
      exp_data = b;
      hist.push_back(b);
      if (MATCH_EN && ends_with("OK\r\n"))      exp_ok++;
      if (MATCH_EN && ends_with("ready\r\n"))   exp_ready++;
    end else begin
      exp_ferr++;
      hist.delete();
    end
  endfunction

  // Drive one 8N1 frame; rx changes on the falling edge.
  task automatic send_frame(input logic [7:0] b, input bit stop,
                            input int hold_low, input int gap);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    if (!stop) begin
      rx = 1'b0;
      repeat (hold_low) @(negedge clk);
    end
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic test_reset;
    sys_rst_n = 1'b0;
    rx        = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got=%h want=00", rx_data); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got=%b want=0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
    checks++; if (ok_det !== 1'b0) begin errors++; $display("FAIL reset_ok_det got=%b want=0", ok_det); end
    checks++; if (ready_det !== 1'b0) begin errors++; $display("FAIL reset_ready_det got=%b want=0", ready_det); end
    sys_rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_byte_55;
    send_frame(8'h55, 1'b1, 0, 8);
    model_frame(8'h55, 1'b1);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL b55_valid_count got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (rx_data !== 8'h55) begin errors++; $display("FAIL b55_data got=%h want=55", rx_data); end
    checks++; if (n_ferr !== exp_ferr) begin errors++; $display("FAIL b55_ferr_count got=%0d want=%0d", n_ferr, exp_ferr); end
  endtask

  task automatic test_glitch;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL glitch_valid_count got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (n_ferr !== exp_ferr) begin errors++; $display("FAIL glitch_ferr_count got=%0d want=%0d", n_ferr, exp_ferr); end
    // Receiver must be idle again and accept the next frame.
    send_frame(8'h3C, 1'b1, 0, 8);
    model_frame(8'h3C, 1'b1);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL glitch_next_valid got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL glitch_next_data got=%h want=%h", rx_data, exp_data); end
  endtask

  task automatic test_frame_err;
    send_frame(8'hA3, 1'b0, 50, 8);
    model_frame(8'hA3, 1'b0);
    checks++; if (n_ferr !== exp_ferr) begin errors++; $display("FAIL ferr_count got=%0d want=%0d", n_ferr, exp_ferr); end
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL ferr_valid_count got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL ferr_data_held got=%h want=%h", rx_data, exp_data); end
    send_frame(8'h41, 1'b1, 0, 8);
    model_frame(8'h41, 1'b1);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL ferr_next_valid got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (rx_data !== 8'h41) begin errors++; $display("FAIL ferr_next_data got=%h want=41", rx_data); end
    checks++; if (n_ferr !== exp_ferr) begin errors++; $display("FAIL ferr_next_ferr got=%0d want=%0d", n_ferr, exp_ferr); end
  endtask

  task automatic send_string(input string s);
    for (int i = 0; i < s.len(); i++) begin
      send_frame(s[i], 1'b1, 0, 6);
      model_frame(s[i], 1'b1);
    end
  endtask

  task automatic test_match_sequences;
    send_string("OOK\r\n");
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL ook_valid_count got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (n_ok !== exp_ok) begin errors++; $display("FAIL ook_ok_count got=%0d want=%0d", n_ok, exp_ok); end
    checks++; if (n_ok_timed !== exp_ok) begin errors++; $display("FAIL ook_ok_timing got=%0d want=%0d", n_ok_timed, exp_ok); end
    checks++; if (n_ready !== exp_ready) begin errors++; $display("FAIL ook_ready_count got=%0d want=%0d", n_ready, exp_ready); end
    send_string("ready\r\n");
    checks++; if (n_ready !== exp_ready) begin errors++; $display("FAIL ready_count got=%0d want=%0d", n_ready, exp_ready); end
    checks++; if (n_ready_timed !== exp_ready) begin errors++; $display("FAIL ready_timing got=%0d want=%0d", n_ready_timed, exp_ready); end
    checks++; if (n_ok !== exp_ok) begin errors++; $display("FAIL ready_ok_count got=%0d want=%0d", n_ok, exp_ok); end
    // Case sensitivity: lower-case "ok" must not match.
    send_string("ok\r\n");
    checks++; if (n_ok !== exp_ok) begin errors++; $display("FAIL lower_ok_count got=%0d want=%0d", n_ok, exp_ok); end
  endtask

  task automatic test_random;
    string      alpha = "OK\r\nreadyx";
    logic [7:0] bytes[$];
    string      tok;
    for (int k = 0; k < 12; k++) begin
      case ($urandom_range(0, 3))
        0: begin tok = "OK\r\n";    for (int i = 0; i < tok.len(); i++) bytes.push_back(tok[i]); end
        1: begin tok = "ready\r\n"; for (int i = 0; i < tok.len(); i++) bytes.push_back(tok[i]); end
        2: bytes.push_back(alpha[$urandom_range(0, alpha.len() - 1)]);
        default: bytes.push_back(8'($urandom_range(0, 255)));
      endcase
    end
    foreach (bytes[j]) begin
      bit stop = ($urandom_range(0, 9) != 0);
      send_frame(bytes[j], stop, $urandom_range(0, 20), $urandom_range(4, 20));
      model_frame(bytes[j], stop);
      checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL rand_valid[%0d] got=%0d want=%0d", j, n_valid, exp_valid); end
      checks++; if (n_ferr !== exp_ferr) begin errors++; $display("FAIL rand_ferr[%0d] got=%0d want=%0d", j, n_ferr, exp_ferr); end
      checks++; if (rx_data !== exp_data) begin errors++; $display("FAIL rand_data[%0d] got=%h want=%h", j, rx_data, exp_data); end
      checks++; if (n_ok !== exp_ok) begin errors++; $display("FAIL rand_ok[%0d] got=%0d want=%0d", j, n_ok, exp_ok); end
      checks++; if (n_ready !== exp_ready) begin errors++; $display("FAIL rand_ready[%0d] got=%0d want=%0d", j, n_ready, exp_ready); end
    end
  endtask

  task automatic test_reset_midbyte;
    logic [7:0] b = 8'hF0;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = b[3];
    repeat (CPB / 2) @(negedge clk);
    sys_rst_n = 1'b0;
    rx        = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h want=00", rx_data); end
    sys_rst_n = 1'b1;
    exp_data  = 8'h00;
    hist.delete();
    repeat (12 * CPB) @(negedge clk);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL midrst_no_valid got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (n_ferr !== exp_ferr) begin errors++; $display("FAIL midrst_no_ferr got=%0d want=%0d", n_ferr, exp_ferr); end
    send_frame(8'h0D, 1'b1, 0, 8);
    model_frame(8'h0D, 1'b1);
    checks++; if (n_valid !== exp_valid) begin errors++; $display("FAIL midrst_next_valid got=%0d want=%0d", n_valid, exp_valid); end
    checks++; if (rx_data !== 8'h0D) begin errors++; $display("FAIL midrst_next_data got=%h want=0D", rx_data); end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    rx        = 1'b1;
    test_reset;
    test_byte_55;
    test_glitch;
    test_frame_err;
    test_match_sequences;
    test_random;
    test_reset_midbyte;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
